// File: rtl/gnn_mlp_seq.sv
// rtl/gnn_mlp_seq.sv - time-multiplexed two-layer per-node perceptron on one shared signed MAC
module gnn_mlp_seq #(
    parameter int N_NODES = 4,
    parameter int N_IN    = 4,
    parameter int N_HID   = 4,
    parameter int N_OUT   = 2,
    parameter int DW      = 5,
    localparam int HW     = 2*DW + $clog2(N_IN),
    localparam int OW     = HW + DW + $clog2(N_HID)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         relu_en,
    input  logic [N_NODES*N_IN*DW-1:0]   x_flat,
    input  logic [N_HID*N_IN*DW-1:0]     w1_flat,
    input  logic [N_OUT*N_HID*DW-1:0]    w2_flat,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_NODES*N_OUT*OW-1:0]  y_flat,
    output logic                         busy
);
    localparam int CW = 8;
    localparam int PW = HW + DW;

    typedef enum logic [1:0] {S_IDLE, S_L1, S_L2, S_DONE} state_t;

    state_t                       state_q;
    logic [N_NODES*N_IN*DW-1:0]   x_q;
    logic [N_HID*N_IN*DW-1:0]     w1_q;
    logic [N_OUT*N_HID*DW-1:0]    w2_q;
    logic                         relu_q;
    logic [CW-1:0]                node_q, neur_q, term_q;
    logic signed [OW-1:0]         acc_q;
    logic signed [HW-1:0]         hid_q [N_HID];
    logic [N_NODES*N_OUT*OW-1:0]  y_q;
    logic                         in_ready_q, out_valid_q, busy_q;

    logic signed [DW-1:0]         x_sel, w1_sel, w2_sel, b_op;
    logic signed [HW-1:0]         hid_sel, a_op, hid_d;
    logic signed [PW-1:0]         prod;
    logic signed [OW-1:0]         sum_d;
    logic                         last_term, last_neur, last_node;

    // Operand muxes: L1 multiplies x[node][term]*w1[neur][term], L2 hid[term]*w2[neur][term].
    always_comb begin
        x_sel   = '0;
        w1_sel  = '0;
        w2_sel  = '0;
        hid_sel = '0;
        for (int n = 0; n < N_NODES; n++)
            for (int i = 0; i < N_IN; i++)
                if (node_q == CW'(n) && term_q == CW'(i))
                    x_sel = x_q[(n*N_IN+i)*DW +: DW];
        for (int h = 0; h < N_HID; h++)
            for (int i = 0; i < N_IN; i++)
                if (neur_q == CW'(h) && term_q == CW'(i))
                    w1_sel = w1_q[(h*N_IN+i)*DW +: DW];
        for (int o = 0; o < N_OUT; o++)
            for (int h = 0; h < N_HID; h++)
                if (neur_q == CW'(o) && term_q == CW'(h))
                    w2_sel = w2_q[(o*N_HID+h)*DW +: DW];
        for (int h = 0; h < N_HID; h++)
            if (term_q == CW'(h))
                hid_sel = hid_q[h];

        if (state_q == S_L2) begin
            a_op = hid_sel;
            b_op = w2_sel;
        end else begin
            a_op = HW'(x_sel);
            b_op = w1_sel;
        end
        prod  = PW'(a_op) * PW'(b_op);
        sum_d = ((term_q == '0) ? '0 : acc_q) + OW'(prod);
        hid_d = (relu_q && sum_d[OW-1]) ? '0 : sum_d[HW-1:0];

        if (state_q == S_L2) begin
            last_term = (term_q == CW'(N_HID-1));
            last_neur = (neur_q == CW'(N_OUT-1));
        end else begin
            last_term = (term_q == CW'(N_IN-1));
            last_neur = (neur_q == CW'(N_HID-1));
        end
        last_node = (node_q == CW'(N_NODES-1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            relu_q      <= 1'b0;
            node_q      <= '0;
            neur_q      <= '0;
            term_q      <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int h = 0; h < N_HID; h++) hid_q[h] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    x_q        <= x_flat;
                    w1_q       <= w1_flat;
                    w2_q       <= w2_flat;
                    relu_q     <= relu_en;
                    node_q     <= '0;
                    neur_q     <= '0;
                    term_q     <= '0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= S_L1;
                end
                S_L1: begin
                    acc_q <= sum_d;
                    if (last_term) begin
                        term_q <= '0;
                        for (int h = 0; h < N_HID; h++)
                            if (neur_q == CW'(h)) hid_q[h] <= hid_d;
                        if (last_neur) begin
                            neur_q  <= '0;
                            state_q <= S_L2;
                        end else begin
                            neur_q <= neur_q + 1'b1;
                        end
                    end else begin
                        term_q <= term_q + 1'b1;
                    end
                end
                S_L2: begin
                    acc_q <= sum_d;
                    if (last_term) begin
                        term_q <= '0;
                        for (int n = 0; n < N_NODES; n++)
                            for (int o = 0; o < N_OUT; o++)
                                if (node_q == CW'(n) && neur_q == CW'(o))
                                    y_q[(n*N_OUT+o)*OW +: OW] <= sum_d;
                        if (last_neur) begin
                            neur_q <= '0;
                            if (last_node) begin
                                busy_q      <= 1'b0;
                                out_valid_q <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                node_q  <= node_q + 1'b1;
                                state_q <= S_L1;
                            end
                        end else begin
                            neur_q <= neur_q + 1'b1;
                        end
                    end else begin
                        term_q <= term_q + 1'b1;
                    end
                end
                S_DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y_flat    = y_q;

endmodule

// File: tb/tb_gnn_mlp_seq.sv
// tb/tb_gnn_mlp_seq.sv - directed bench for gnn_mlp_seq at default and reduced geometry
module tb_gnn_mlp_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, relu_en, out_valid, out_ready, busy;
    logic [79:0]  x_flat;
    logic [79:0]  w1_flat;
    logic [39:0]  w2_flat;
    logic [151:0] y_flat;

    logic         in_valid2, in_ready2, relu_en2, out_valid2, out_ready2, busy2;
    logic [47:0]  x2_flat;
    logic [95:0]  w12_flat;
    logic [63:0]  w22_flat;
    logic [111:0] y2_flat;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    gnn_mlp_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .relu_en(relu_en),
        .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat), .out_valid(out_valid),
        .out_ready(out_ready), .y_flat(y_flat), .busy(busy)
    );

    gnn_mlp_seq #(.N_NODES(2), .N_IN(3), .DW(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .relu_en(relu_en2),
        .x_flat(x2_flat), .w1_flat(w12_flat), .w2_flat(w22_flat), .out_valid(out_valid2),
        .out_ready(out_ready2), .y_flat(y2_flat), .busy(busy2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int yv(input int n, input int o);
        logic signed [18:0] t;
        t = y_flat[(n*2+o)*19 +: 19];
        return int'(t);
    endfunction

    function automatic int yv2(input int n, input int o);
        logic signed [27:0] t;
        t = y2_flat[(n*2+o)*28 +: 28];
        return int'(t);
    endfunction

    // x[n][i] = xbase + xstep*n, all w1 = w1v, all w2 = w2v
    task automatic load(input int xbase, input int xstep, input int w1v, input int w2v, input bit relu);
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 4; i++)
                x_flat[(n*4+i)*5 +: 5] = 5'(xbase + xstep*n);
        for (int k = 0; k < 16; k++) w1_flat[k*5 +: 5] = 5'(w1v);
        for (int k = 0; k < 8; k++)  w2_flat[k*5 +: 5] = 5'(w2v);
        relu_en = relu;
    endtask

    // Pulse in_valid at T0, then follow the frame to out_valid; expected y[n][o] = ybase + ystep*n.
    task automatic run_frame(input string tag, input int ybase, input int ystep);
        int cyc;
        int busy_cnt;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        busy_cnt = busy ? 1 : 0;
        while (!out_valid && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_cnt++;
        end
        chk({tag, "_lat"}, cyc, 96);
        chk({tag, "_busy_cycles"}, busy_cnt, 96);
        for (int n = 0; n < 4; n++)
            for (int o = 0; o < 2; o++)
                chk($sformatf("%s_y%0d%0d", tag, n, o), yv(n, o), ybase + ystep*n);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_hs_in_ready"}, int'(in_ready), 1);
        chk({tag, "_hs_out_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        logic [151:0] snap;
        int cyc;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; relu_en = 1'b0;
        x_flat = '0; w1_flat = '0; w2_flat = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; relu_en2 = 1'b0;
        x2_flat = '0; w12_flat = '0; w22_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_y_zero", int'(|y_flat), 0);

        load(15, 0, 15, 15, 1'b1);
        run_frame("pos15", 54000, 0);
        handshake("pos15");

        load(-16, 0, -16, -16, 1'b0);
        run_frame("neg16_norelu", -65536, 0);
        handshake("neg16_norelu");
        load(-16, 0, -16, -16, 1'b1);
        run_frame("neg16_relu", -65536, 0);
        handshake("neg16_relu");

        load(1, 0, -1, 1, 1'b1);
        run_frame("relu_on", 0, 0);
        handshake("relu_on");
        load(1, 0, -1, 1, 1'b0);
        run_frame("relu_off", -16, 0);
        handshake("relu_off");

        load(1, 1, 1, 1, 1'b1);
        run_frame("per_node", 16, 16);
        handshake("per_node");

        // Backpressure: result held for 10 cycles while a second frame is offered and ignored.
        out_ready = 1'b0;
        load(15, 0, 15, 15, 1'b1);
        run_frame("bp_first", 54000, 0);
        snap = y_flat;
        load(1, 1, 1, 1, 1'b1);
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_out_valid_%0d", k), int'(out_valid), 1);
            chk($sformatf("bp_in_ready_%0d", k), int'(in_ready), 0);
            chk($sformatf("bp_y_stable_%0d", k), int'(y_flat == snap), 1);
        end
        in_valid = 1'b0;
        handshake("bp");
        chk("bp_not_started", int'(busy), 0);
        run_frame("bp_second", 16, 16);
        handshake("bp_second");

        // Reset at T0+40 abandons the frame.
        load(-16, 0, -16, -16, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        chk("mid_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_y_zero", int'(|y_flat), 0);
        load(1, 0, -1, 1, 1'b0);
        run_frame("after_rst", -16, 0);
        handshake("after_rst");

        // Reduced geometry: 2 nodes, 3 inputs, 8-bit data; y[n][o] = 4*3*(n+1).
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < 3; i++)
                x2_flat[(n*3+i)*8 +: 8] = 8'(n + 1);
        for (int k = 0; k < 12; k++) w12_flat[k*8 +: 8] = 8'd1;
        for (int k = 0; k < 8; k++)  w22_flat[k*8 +: 8] = 8'd1;
        relu_en2 = 1'b1;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        cyc = 0;
        while (!out_valid2 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("small_lat", cyc, 40);
        for (int n = 0; n < 2; n++)
            for (int o = 0; o < 2; o++)
                chk($sformatf("small_y%0d%0d", n, o), yv2(n, o), 12*(n + 1));
        @(posedge clk);
        #1;
        chk("small_hs_in_ready", int'(in_ready2), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
